// File: rtl/key_evt_pkg.sv
// Shared types and widths for the key event generator.
package key_evt_pkg;

  localparam int MS_W  = 16;  // millisecond counter width
  localparam int CNT_W = 8;   // press counter width

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRESS = 2'd1,
    HOLD  = 2'd2,
    GAP   = 2'd3
  } state_t;

endpackage

// File: rtl/ms_tick_gen.sv
// Millisecond tick generator: free-running divider 0..TICK_DIV-1 that
// raises a registered one-cycle tick each time it wraps back to 0.
module ms_tick_gen #(
  parameter int TICK_DIV = 50000
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(TICK_DIV - 1);

  logic [DIV_W-1:0] div_cnt;

  // Divider count and tick strobe; tick is high while the count sits at 0.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      div_cnt <= '0;
      tick    <= 1'b0;
    end else if (div_cnt == DIV_MAX) begin
      div_cnt <= '0;
      tick    <= 1'b1;
    end else begin
      div_cnt <= div_cnt + 1'b1;
      tick    <= 1'b0;
    end
  end

endmodule

// File: rtl/key_event_gen.sv
// Key event generator: turns the debounced key level into one-cycle
// press / release / long-press / auto-repeat / double-click pulses and
// keeps a wrapping press counter. All outputs are registered.
// Build option: define KEY_EVT_REPEAT_EN to enable auto-repeat in HOLD;
// without it repeat_pls stays 0 and HOLD only waits for the release.
module key_event_gen
  import key_evt_pkg::*;
#(
  parameter int TICK_DIV  = 50000,
  parameter int LONG_MS   = 1000,
  parameter int REPEAT_MS = 200,
  parameter int DBL_MS    = 300
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             key,
  output logic             press_pls,
  output logic             release_pls,
  output logic             long_pls,
  output logic             repeat_pls,
  output logic             dbl_pls,
  output logic [CNT_W-1:0] press_cnt,
  output logic             busy
);

  // Reject parameter values the counters cannot represent.
  if (LONG_MS < 2 || LONG_MS > 65535) begin : g_bad_long
    $error("key_event_gen: LONG_MS out of range 2..65535");
  end
  if (REPEAT_MS < 1 || REPEAT_MS > 65535) begin : g_bad_repeat
    $error("key_event_gen: REPEAT_MS out of range 1..65535");
  end
  if (DBL_MS < 1 || DBL_MS > 65535) begin : g_bad_dbl
    $error("key_event_gen: DBL_MS out of range 1..65535");
  end

  // Timeouts fire on the tick that would take ms_cnt to the limit.
  localparam logic [MS_W-1:0] LONG_LAST = MS_W'(LONG_MS - 1);
  localparam logic [MS_W-1:0] DBL_LAST  = MS_W'(DBL_MS - 1);
`ifdef KEY_EVT_REPEAT_EN
  localparam logic [MS_W-1:0] REP_LAST  = MS_W'(REPEAT_MS - 1);
`endif
  localparam logic [MS_W-1:0] MS_MAX    = '1;

  state_t           state, state_n;
  logic             key_d;
  logic             rise, fall;
  logic             tick;
  logic [MS_W-1:0]  ms_cnt, ms_n;
  logic             ms_clr;
  logic [CNT_W-1:0] cnt_n;
  logic             press_n, release_n, long_n, repeat_n, dbl_n;

  ms_tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  assign rise = key & ~key_d;
  assign fall = ~key & key_d;

  // Next-state and next-pulse decode; key edges take priority over timeouts.
  always_comb begin
    // NOTE: every output of this block gets a default before the case so no
    // path leaves a variable unassigned, which would infer a latch.
    state_n   = state;
    ms_clr    = 1'b0;
    press_n   = 1'b0;
    release_n = 1'b0;
    long_n    = 1'b0;
    repeat_n  = 1'b0;
    dbl_n     = 1'b0;

    case (state)
      IDLE: begin
        if (rise) begin
          press_n = 1'b1;
          state_n = PRESS;
        end
      end
      PRESS: begin
        if (fall) begin
          release_n = 1'b1;
          state_n   = GAP;
        end else if (tick && ms_cnt == LONG_LAST) begin
          long_n  = 1'b1;
          state_n = HOLD;
        end
      end
      HOLD: begin
        // A long press never arms the double-click window.
        if (fall) begin
          release_n = 1'b1;
          state_n   = IDLE;
        end
`ifdef KEY_EVT_REPEAT_EN
        else if (tick && ms_cnt == REP_LAST) begin
          repeat_n = 1'b1;
          ms_clr   = 1'b1;
        end
`endif
      end
      GAP: begin
        if (rise) begin
          press_n = 1'b1;
          dbl_n   = 1'b1;
          state_n = PRESS;
        end else if (tick && ms_cnt == DBL_LAST) begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase

    // Every state change restarts the millisecond count.
    if (state_n != state) ms_clr = 1'b1;

    if (ms_clr)                          ms_n = '0;
    else if (tick && ms_cnt != MS_MAX)   ms_n = ms_cnt + 1'b1;
    else                                 ms_n = ms_cnt;

    cnt_n = press_cnt + CNT_W'(press_n);
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      key_d       <= 1'b0;
      ms_cnt      <= '0;
      press_cnt   <= '0;
      press_pls   <= 1'b0;
      release_pls <= 1'b0;
      long_pls    <= 1'b0;
      repeat_pls  <= 1'b0;
      dbl_pls     <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state       <= state_n;
      key_d       <= key;
      ms_cnt      <= ms_n;
      press_cnt   <= cnt_n;
      press_pls   <= press_n;
      release_pls <= release_n;
      long_pls    <= long_n;
      repeat_pls  <= repeat_n;
      dbl_pls     <= dbl_n;
      busy        <= (state_n != IDLE);
    end
  end

endmodule
